// File: rtl/lane_seg_div_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIN0_W / DIN1_W / DOUT_W : default dividend / divisor / quotient widths
//   div_state_t              : divider FSM states
//   SAT_MAX / SAT_MIN        : quotient saturation limits
package lane_seg_div_pkg;
  localparam int DIN0_W = 28;
  localparam int DIN1_W = 13;
  localparam int DOUT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/lane_seg_div_step.sv
// One unsigned restoring shift-subtract step (purely combinational).
//   prem : partial remainder in     dbit : next dividend bit shifted in
//   dvsr : divisor magnitude        nrem : next partial remainder
//   qbit : quotient bit produced by this step
module lane_seg_div_step #(
  parameter int W = 13
) (
  input  logic [W-1:0] prem,
  input  logic         dbit,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] nrem,
  output logic         qbit
);
  logic [W:0] trial;

  always_comb begin
    trial = {prem, dbit};
    qbit  = (trial >= {1'b0, dvsr});
    // After a successful subtract the result is < dvsr, so W bits suffice
    // and the carry-out bit can be dropped.
    nrem  = qbit ? (trial[W-1:0] - dvsr) : trial[W-1:0];
  end
endmodule

// File: rtl/lane_seg_top_sdiv_28s_13s_16_seq.sv
// Sequential signed divider: dout = din0 / din1, truncated toward zero and
// saturated to the dout range, one quotient bit per cycle.
//   ap_clk, ap_rst_n        : clock, synchronous active-low reset
//   din_valid/din_ready     : operand handshake (ready only while idle)
//   din0, din1              : signed dividend / divisor
//   dout_valid/dout_ready   : result handshake, result held until taken
//   dout, ovf, dz           : quotient, saturation flag, divide-by-zero flag
//   rem                     : signed remainder (only with LANE_SEG_DIV_REM_EN)
// Optional feature macro: LANE_SEG_DIV_REM_EN adds the remainder output.
module lane_seg_top_sdiv_28s_13s_16_seq
  import lane_seg_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  dz
`ifdef LANE_SEG_DIV_REM_EN
  ,output logic [din1_WIDTH-1:0] rem
`endif
);
  localparam int CW = $clog2(din0_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(din0_WIDTH - 1);

  div_state_t            state;
  logic [CW-1:0]         cnt;
  logic [din0_WIDTH-1:0] a;      // dividend magnitude, becomes quotient
  logic [din1_WIDTH-1:0] d;      // divisor magnitude
  logic [din1_WIDTH-1:0] r;      // partial remainder
  logic                  s0, s1; // operand signs

  logic [din0_WIDTH-1:0] mag0;
  logic [din1_WIDTH-1:0] mag1;
  logic [din1_WIDTH-1:0] r_nxt;
  logic                  qbit;

  // Magnitudes as unsigned values so the most negative inputs still fit.
  assign mag0 = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
  assign mag1 = din1[din1_WIDTH-1] ? (~din1 + 1'b1) : din1;

  lane_seg_div_step #(.W(din1_WIDTH)) u_step (
    .prem (r),
    .dbit (a[din0_WIDTH-1]),
    .dvsr (d),
    .nrem (r_nxt),
    .qbit (qbit)
  );

  // Sign application and saturation, registered in FIX.
  logic [din0_WIDTH-1:0] lim_pos, lim_neg;
  logic                  q_neg;
  logic [dout_WIDTH-1:0] fix_dout;
  logic                  fix_ovf, fix_dz;

  assign lim_pos = din0_WIDTH'(SAT_MAX);
  assign lim_neg = lim_pos + 1'b1;

  always_comb begin
    fix_dz  = (d == '0);
    fix_ovf = 1'b0;
    q_neg   = (s0 ^ s1) && (a != '0);
    if (fix_dz) begin
      fix_dout = s0 ? dout_WIDTH'(SAT_MIN) : dout_WIDTH'(SAT_MAX);
    end else if (q_neg) begin
      if (a > lim_neg) begin
        fix_dout = dout_WIDTH'(SAT_MIN);
        fix_ovf  = 1'b1;
      end else begin
        fix_dout = -a[dout_WIDTH-1:0];
      end
    end else if (a > lim_pos) begin
      fix_dout = dout_WIDTH'(SAT_MAX);
      fix_ovf  = 1'b1;
    end else begin
      fix_dout = a[dout_WIDTH-1:0];
    end
  end

`ifdef LANE_SEG_DIV_REM_EN
  // Remainder follows the dividend's sign; forced to 0 on divide-by-zero.
  logic [din1_WIDTH-1:0] fix_rem;
  assign fix_rem = fix_dz ? '0 : (s0 ? (~r + 1'b1) : r);
`endif

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
      dout       <= '0;
      ovf        <= 1'b0;
      dz         <= 1'b0;
      cnt        <= '0;
      a          <= '0;
      d          <= '0;
      r          <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
`ifdef LANE_SEG_DIV_REM_EN
      rem        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (din_valid && din_ready) begin
          a         <= mag0;
          d         <= mag1;
          r         <= '0;
          s0        <= din0[din0_WIDTH-1];
          s1        <= din1[din1_WIDTH-1];
          cnt       <= '0;
          din_ready <= 1'b0;
          state     <= CALC;
        end
        CALC: begin
          // Quotient bits shift in from the bottom as dividend bits leave the top.
          a   <= {a[din0_WIDTH-2:0], qbit};
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          dout       <= fix_dout;
          ovf        <= fix_ovf;
          dz         <= fix_dz;
`ifdef LANE_SEG_DIV_REM_EN
          rem        <= fix_rem;
`endif
          dout_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: if (dout_ready) begin
          dout_valid <= 1'b0;
          din_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_seg_top_sdiv_28s_13s_16_seq.sv
// Self-checking bench for lane_seg_top_sdiv_28s_13s_16_seq: directed corner
// cases plus randomized operands against an integer-arithmetic model.
module tb_lane_seg_top_sdiv_28s_13s_16_seq;
  localparam int W0 = 28;
  localparam int W1 = 13;
  localparam int WO = 16;
  // Edges from the accept edge to the edge that raises dout_valid
  // (28 steps + the sign/saturate cycle); the accept cycle is cycle 0,
  // so dout_valid is first high in cycle 30.
  localparam int LAT = 29;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          din_valid = 1'b0;
  logic          dout_ready = 1'b0;
  logic [W0-1:0] din0 = '0;
  logic [W1-1:0] din1 = '0;
  logic          din_ready, dout_valid, ovf, dz;
  logic [WO-1:0] dout;
`ifdef LANE_SEG_DIV_REM_EN
  logic [W1-1:0] rem;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  lane_seg_top_sdiv_28s_13s_16_seq #(
    .ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din0       (din0),
    .din1       (din1),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .ovf        (ovf),
    .dz         (dz)
`ifdef LANE_SEG_DIV_REM_EN
    ,.rem       (rem)
`endif
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference: plain signed division (truncating), remainder with the
  // dividend's sign, then saturation to the 16-bit signed range.
  task automatic model(input longint a, input longint b,
                       output longint q, output longint r,
                       output longint o, output longint z);
    if (b == 0) begin
      z = 1; o = 0; r = 0;
      q = (a < 0) ? -32768 : 32767;
    end else begin
      z = 0; o = 0;
      q = a / b;
      r = a % b;
      if (q > 32767) begin q = 32767; o = 1; end
      else if (q < -32768) begin q = -32768; o = 1; end
    end
  endtask

  task automatic run_op(input longint a, input longint b, input int hold);
    longint eq, er, eo, ez;
    int     lat;
    model(a, b, eq, er, eo, ez);
    lat = 0;
    while (!din_ready && lat < 100) begin
      @(posedge ap_clk); #1; lat++;
    end
    chk("din_ready_idle", longint'(din_ready), 1);
    @(negedge ap_clk);
    din0 = W0'(a);
    din1 = W1'(b);
    din_valid = 1'b1;
    @(posedge ap_clk); #1;
    din_valid = 1'b0;
    chk("din_ready_busy", longint'(din_ready), 0);
    lat = 0;
    while (!dout_valid && lat < 100) begin
      @(posedge ap_clk); #1; lat++;
    end
    chk("latency", lat, LAT);
    chk("dout", longint'($signed(dout)), eq);
    chk("ovf", longint'(ovf), eo);
    chk("dz", longint'(dz), ez);
`ifdef LANE_SEG_DIV_REM_EN
    chk("rem", longint'($signed(rem)), er);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge ap_clk); #1;
      chk("hold_valid", longint'(dout_valid), 1);
      chk("hold_dout", longint'($signed(dout)), eq);
      chk("hold_flags", longint'({ovf, dz}), (eo << 1) | ez);
      chk("hold_din_ready", longint'(din_ready), 0);
    end
    @(negedge ap_clk);
    dout_ready = 1'b1;
    @(posedge ap_clk); #1;
    dout_ready = 1'b0;
    chk("release_valid", longint'(dout_valid), 0);
    chk("release_ready", longint'(din_ready), 1);
  endtask

  initial begin
    int seen;
    longint a, b;
    logic signed [W0-1:0] ra;
    logic signed [W1-1:0] rb;

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("rst_din_ready", longint'(din_ready), 1);
    chk("rst_dout_valid", longint'(dout_valid), 0);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_flags", longint'({ovf, dz}), 0);
`ifdef LANE_SEG_DIV_REM_EN
    chk("rst_rem", longint'(rem), 0);
`endif

    // Directed cases
    run_op(1000000, 100, 0);
    run_op(-1000, 7, 0);
    run_op(1000, -7, 0);
    run_op(134217727, 1, 0);
    run_op(-134217728, 1, 0);
    run_op(5, 0, 0);
    run_op(-5, 0, 0);
    run_op(-32768, 1, 0);
    run_op(32768, -1, 0);
    run_op(32768, 1, 0);
    run_op(-134217728, -4096, 0);
    run_op(3, -4096, 0);
    run_op(1000000, 100, 10);

    // Reset in the middle of CALC abandons the operation.
    @(negedge ap_clk);
    din0 = W0'(500); din1 = W1'(7); din_valid = 1'b1;
    @(posedge ap_clk); #1;
    din_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    chk("midrst_din_ready", longint'(din_ready), 1);
    chk("midrst_dout_valid", longint'(dout_valid), 0);
    seen = 0;
    repeat (40) begin
      @(posedge ap_clk); #1;
      if (dout_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    run_op(20, 3, 0);

    // Randomized operands
    for (int n = 0; n < 40; n++) begin
      ra = W0'($urandom);
      rb = W1'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: ra = W0'($signed(20'($urandom)));
        2: rb = '0;
        default: rb = ($urandom_range(0, 1) == 1) ? W1'(1) : W1'(-1);
      endcase
      a = longint'(ra);
      b = longint'(rb);
      run_op(a, b, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
